// File: rtl/fetch_unit.sv
// fetch_unit -- two-phase instruction fetch sequencer.
//
// Each instruction takes two run cycles. In FETCH the program word at
// address==pc is latched into {instr, operand} and pc advances by one. In
// EXEC the latched instruction either halts the unit (instr == HALT_OP) or
// returns to FETCH, optionally jumping to load_addr. HALT is left only by
// reset. When run is low, everything holds.
//
// Optional feature: define FETCH_PC_OVF_EN to build the sticky pc_ovf flag.
// It sets when the fetch increment wraps pc from all-ones to zero. A jump
// to zero does not set it. Without the macro, pc_ovf is tied to 0 and no
// detection logic is built.
//
// Ports:
//   clock      in   1        rising-edge clock
//   reset      in   1        asynchronous active-low reset
//   run        in   1        advance when 1, hold everything when 0
//   load       in   1        jump request, honoured only in EXEC
//   load_addr  in   ADDR_W   jump target
//   prog_word  in   WORD_W   program memory read data (combinational)
//   address    out  ADDR_W   program memory address (equals pc)
//   pc         out  ADDR_W   program counter
//   instr      out  INSTR_W  upper field of the latched word
//   operand    out  WORD_W-INSTR_W  lower field of the latched word
//   phase      out  1        0 = FETCH, 1 = EXEC
//   halted     out  1        1 in HALT
//   pc_ovf     out  1        sticky pc wrap flag
module fetch_unit #(
  parameter int                 ADDR_W  = 12,
  parameter int                 WORD_W  = 8,
  parameter int                 INSTR_W = 4,
  parameter logic [INSTR_W-1:0] HALT_OP = 4'hF
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       run,
  input  logic                       load,
  input  logic [ADDR_W-1:0]          load_addr,
  input  logic [WORD_W-1:0]          prog_word,
  output logic [ADDR_W-1:0]          address,
  output logic [ADDR_W-1:0]          pc,
  output logic [INSTR_W-1:0]         instr,
  output logic [WORD_W-INSTR_W-1:0]  operand,
  output logic                       phase,
  output logic                       halted,
  output logic                       pc_ovf
);

  localparam int OPND_W = WORD_W - INSTR_W;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t              state_q, state_nxt;
  logic [ADDR_W-1:0]   pc_q, pc_nxt;
  logic [WORD_W-1:0]   word_q, word_nxt;

  // Next-state and datapath selection
  always_comb begin
    state_nxt = state_q;
    pc_nxt    = pc_q;
    word_nxt  = word_q;
    if (run) begin
      unique case (state_q)
        FETCH: begin
          word_nxt  = prog_word;
          pc_nxt    = pc_q + ADDR_W'(1);
          state_nxt = EXEC;
        end
        EXEC: begin
          // A halting instruction ignores load and keeps pc.
          if (word_q[WORD_W-1 -: INSTR_W] == HALT_OP) begin
            state_nxt = HALT;
          end else begin
            if (load) pc_nxt = load_addr;
            state_nxt = FETCH;
          end
        end
        HALT:    state_nxt = HALT;
        default: state_nxt = FETCH;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      pc_q    <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_nxt;
      pc_q    <= pc_nxt;
      word_q  <= word_nxt;
    end
  end

`ifdef FETCH_PC_OVF_EN
  logic ovf_q;
  logic wrap;

  // Only the fetch increment can wrap. A jump to zero leaves the flag alone.
  assign wrap = run && (state_q == FETCH) && (pc_q == {ADDR_W{1'b1}});

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
    end else if (wrap) begin
      ovf_q <= 1'b1;
    end
  end

  assign pc_ovf = ovf_q;
`else
  assign pc_ovf = 1'b0;
`endif

  assign address = pc_q;
  assign pc      = pc_q;
  assign instr   = word_q[WORD_W-1 -: INSTR_W];
  assign operand = word_q[OPND_W-1:0];
  assign phase   = (state_q == EXEC);
  assign halted  = (state_q == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed sequence with literal expectations plus
// a behavioural reference model compared on every falling clock edge.
module tb_fetch_unit;

`ifdef FETCH_PC_OVF_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic        load = 1'b0;
  logic [11:0] load_addr = '0;
  logic [7:0]  prog_word;
  logic [11:0] address, pc;
  logic [3:0]  instr, operand;
  logic        phase, halted, pc_ovf;

  logic [7:0]  rom [0:4095];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  assign prog_word = rom[address];

  fetch_unit dut (
    .clock(clock), .reset(reset), .run(run), .load(load),
    .load_addr(load_addr), .prog_word(prog_word), .address(address),
    .pc(pc), .instr(instr), .operand(operand), .phase(phase),
    .halted(halted), .pc_ovf(pc_ovf)
  );

  // Reference model: 0 = fetching, 1 = executing, 2 = halted.
  int          m_st;
  logic [11:0] m_pc;
  logic [7:0]  m_word;
  logic        m_ovf;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_st <= 0; m_pc <= '0; m_word <= '0; m_ovf <= 1'b0;
    end else if (run) begin
      if (m_st == 0) begin
        m_word <= rom[m_pc];
        m_pc   <= m_pc + 12'd1;
        if (m_pc == 12'hFFF && OVF_EN) m_ovf <= 1'b1;
        m_st   <= 1;
      end else if (m_st == 1) begin
        if (m_word[7:4] == 4'hF) m_st <= 2;
        else begin
          if (load) m_pc <= load_addr;
          m_st <= 0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (reset) begin
      check("m_address", 32'(address), 32'(m_pc));
      check("m_pc",      32'(pc),      32'(m_pc));
      check("m_instr",   32'(instr),   32'(m_word[7:4]));
      check("m_operand", 32'(operand), 32'(m_word[3:0]));
      check("m_phase",   32'(phase),   32'(m_st == 1));
      check("m_halted",  32'(halted),  32'(m_st == 2));
      check("m_pc_ovf",  32'(pc_ovf),  32'(m_ovf));
    end
  end

  task automatic step(input logic r, input logic l, input logic [11:0] a);
    run = r; load = l; load_addr = a;
    @(posedge clock); #1;
  endtask

  task automatic expect_out(input string tag, input logic [11:0] e_pc, input logic [3:0] e_in,
                            input logic [3:0] e_op, input logic e_ph, input logic e_h);
    check({tag, "_pc"},      32'(pc),      32'(e_pc));
    check({tag, "_addr"},    32'(address), 32'(e_pc));
    check({tag, "_instr"},   32'(instr),   32'(e_in));
    check({tag, "_operand"}, 32'(operand), 32'(e_op));
    check({tag, "_phase"},   32'(phase),   32'(e_ph));
    check({tag, "_halted"},  32'(halted),  32'(e_h));
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    rom[0] = 8'h3A; rom[1] = 8'h51; rom[2] = 8'hF2;
    rom[12'h7F0] = 8'h12; rom[12'h7F1] = 8'h34; rom[12'hFFF] = 8'h27;

    repeat (2) @(posedge clock);
    #1;
    expect_out("rst", 12'h000, 4'h0, 4'h0, 1'b0, 1'b0);
    check("rst_ovf", 32'(pc_ovf), 32'd0);
    reset = 1'b1;

    // Basic two-cycle fetch/exec of 3A, 51
    step(1, 0, 0); expect_out("c1", 12'h001, 4'h3, 4'hA, 1'b1, 1'b0);
    step(1, 0, 0); expect_out("c2", 12'h001, 4'h3, 4'hA, 1'b0, 1'b0);
    step(1, 0, 0); expect_out("c3", 12'h002, 4'h5, 4'h1, 1'b1, 1'b0);

    // Jump, then load held through FETCH has no effect
    step(1, 1, 12'h7F0); expect_out("jmp", 12'h7F0, 4'h5, 4'h1, 1'b0, 1'b0);
    step(1, 1, 12'h7F0); expect_out("ldf", 12'h7F1, 4'h1, 4'h2, 1'b1, 1'b0);

    // Stall in EXEC, then in FETCH
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 12'h000); expect_out("stx", 12'h7F1, 4'h1, 4'h2, 1'b1, 1'b0);
    end
    step(1, 0, 0); expect_out("rsx", 12'h7F1, 4'h1, 4'h2, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 12'hABC); expect_out("stf", 12'h7F1, 4'h1, 4'h2, 1'b0, 1'b0);
    end
    step(1, 0, 0); expect_out("rsf", 12'h7F2, 4'h3, 4'h4, 1'b1, 1'b0);

    // Jump to 0 must not set the wrap flag
    step(1, 1, 12'h000); expect_out("j0", 12'h000, 4'h3, 4'h4, 1'b0, 1'b0);
    check("j0_ovf", 32'(pc_ovf), 32'd0);
    step(1, 0, 0); expect_out("f0", 12'h001, 4'h3, 4'hA, 1'b1, 1'b0);

    // Jump to the top and wrap
    step(1, 1, 12'hFFF); expect_out("jtop", 12'hFFF, 4'h3, 4'hA, 1'b0, 1'b0);
    step(1, 0, 0); expect_out("wrap", 12'h000, 4'h2, 4'h7, 1'b1, 1'b0);
    check("wrap_ovf", 32'(pc_ovf), 32'(OVF_EN));
    step(1, 1, 12'h000); check("j0b_ovf", 32'(pc_ovf), 32'(OVF_EN));
    step(1, 0, 0); expect_out("f0b", 12'h001, 4'h3, 4'hA, 1'b1, 1'b0);

    // Asynchronous reset in EXEC with load pending
    run = 1'b1; load = 1'b1; load_addr = 12'h123;
    #1 reset = 1'b0;
    #1 expect_out("arst", 12'h000, 4'h0, 4'h0, 1'b0, 1'b0);
    check("arst_ovf", 32'(pc_ovf), 32'd0);
    @(posedge clock); #1;
    expect_out("arst2", 12'h000, 4'h0, 4'h0, 1'b0, 1'b0);
    load = 1'b0;
    reset = 1'b1;
    check("rel_addr", 32'(address), 32'd0);

    // Run into HALT: 3A, 51, F2
    step(1, 0, 0); expect_out("h1", 12'h001, 4'h3, 4'hA, 1'b1, 1'b0);
    step(1, 0, 0);
    step(1, 0, 0); expect_out("h3", 12'h002, 4'h5, 4'h1, 1'b1, 1'b0);
    step(1, 0, 0);
    step(1, 0, 0); expect_out("h5", 12'h003, 4'hF, 4'h2, 1'b1, 1'b0);
    step(1, 1, 12'h555); expect_out("halt", 12'h003, 4'hF, 4'h2, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 12'h555); expect_out("hold", 12'h003, 4'hF, 4'h2, 1'b0, 1'b1);
    end

    @(negedge clock); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
